id_ex_stage: RTL and testbench

- Decode-to-execute stage of the 5-stage MIPS pipeline, directly upstream of the ALU.
- Holds the 32x32 register file (2 read ports, 1 write port, write-through bypass) and sign-extends the immediate.
- Selects ALU operands (srca/srcb) and the destination register, and registers everything into the E-stage pipeline register.
- Detects load-use hazards and inserts bubbles on stall or branch flush.

---
 rtl/mips_pkg.sv | 38 +++
 rtl/reg_file_2r1w.sv | 49 ++++
 rtl/id_ex_stage.sv | 115 +++++++++++
 tb/tb_id_ex_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: datapath sizes, ALU encodings, instruction fields
// and the control bundle carried into the E stage.
package mips_pkg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned NumRegs = 2 ** REG_AW;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  localparam int unsigned RsLsb    = 21;
  localparam int unsigned RtLsb    = 16;
  localparam int unsigned RdLsb    = 11;
  localparam int unsigned ImmWidth = 16;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic [2:0] alucontrol;
  } ctrl_e_t;

  localparam ctrl_e_t CtrlBubble = '{
    regwrite:   1'b0,
    memtoreg:   1'b0,
    memwrite:   1'b0,
    alucontrol: AluAnd
  };

  function automatic logic [WIDTH-1:0] sign_ext(input logic [ImmWidth-1:0] imm);
    return {{(WIDTH - ImmWidth){imm[ImmWidth-1]}}, imm};
  endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// 32-entry register file, two combinational read ports and one write port.
// $0 is hard-wired to zero; a same-cycle write is bypassed to the readers.
module reg_file_2r1w
  import mips_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [REG_AW-1:0] ra1_i,
  input  logic [REG_AW-1:0] ra2_i,
  output logic [WIDTH-1:0]  rd1_o,
  output logic [WIDTH-1:0]  rd2_o,
  input  logic              we3_i,
  input  logic [REG_AW-1:0] wa3_i,
  input  logic [WIDTH-1:0]  wd3_i
);

  logic [WIDTH-1:0] mem_q [NumRegs];
  logic [WIDTH-1:0] mem_d [NumRegs];
  logic             wr_en;

  assign wr_en = we3_i && (wa3_i != '0);

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wa3_i] = wd3_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rd1_o = '0;
    rd2_o = '0;
    if (ra1_i != '0) begin
      rd1_o = (wr_en && (wa3_i == ra1_i)) ? wd3_i : mem_q[ra1_i];
    end
    if (ra2_i != '0) begin
      rd2_o = (wr_en && (wa3_i == ra2_i)) ? wd3_i : mem_q[ra2_i];
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute stage: register read, operand select, load-use stall detection
// and the E-stage pipeline register (bubble on flush or stall).
module id_ex_stage
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  instr_d,
  input  logic              valid_d,
  input  logic              regwrite_d,
  input  logic              memtoreg_d,
  input  logic              memwrite_d,
  input  logic              alusrc_d,
  input  logic              regdst_d,
  input  logic [2:0]        alucontrol_d,
  input  logic              we3,
  input  logic [REG_AW-1:0] wa3,
  input  logic [WIDTH-1:0]  wd3,
  input  logic              flush_e,
  output logic [WIDTH-1:0]  srca_e,
  output logic [WIDTH-1:0]  srcb_e,
  output logic [WIDTH-1:0]  writedata_e,
  output logic [2:0]        alucontrol_e,
  output logic [REG_AW-1:0] writereg_e,
  output logic              regwrite_e,
  output logic              memtoreg_e,
  output logic              memwrite_e,
  output logic              valid_e,
  output logic              stall_d
);

  logic [REG_AW-1:0] rs, rt, rd;
  logic [WIDTH-1:0]  signimm, rd1, rd2;
  logic              uses_rt;
  logic              unused_opcode;

  logic              valid_e_q, valid_e_d;
  ctrl_e_t           ctrl_e_q, ctrl_e_d;
  logic [REG_AW-1:0] writereg_e_q, writereg_e_d;
  logic [WIDTH-1:0]  srca_e_q, srca_e_d;
  logic [WIDTH-1:0]  srcb_e_q, srcb_e_d;
  logic [WIDTH-1:0]  writedata_e_q, writedata_e_d;

  assign rs            = instr_d[RsLsb +: REG_AW];
  assign rt            = instr_d[RtLsb +: REG_AW];
  assign rd            = instr_d[RdLsb +: REG_AW];
  assign signimm       = sign_ext(instr_d[ImmWidth-1:0]);
  assign unused_opcode = ^instr_d[WIDTH-1:RsLsb+REG_AW];

  reg_file_2r1w u_reg_file (
    .clk_i  (clk),
    .rst_ni (reset),
    .ra1_i  (rs),
    .ra2_i  (rt),
    .rd1_o  (rd1),
    .rd2_o  (rd2),
    .we3_i  (we3),
    .wa3_i  (wa3),
    .wd3_i  (wd3)
  );

  // Immediate-form ALU ops only read rt when it is the store data.
  assign uses_rt = !alusrc_d || memwrite_d;

  assign stall_d = valid_d && valid_e_q && ctrl_e_q.memtoreg && ctrl_e_q.regwrite &&
                   (writereg_e_q != '0) &&
                   ((writereg_e_q == rs) || (uses_rt && (writereg_e_q == rt)));

  always_comb begin
    valid_e_d     = valid_d;
    ctrl_e_d      = valid_d ? ctrl_e_t'{regwrite_d, memtoreg_d, memwrite_d, alucontrol_d}
                            : CtrlBubble;
    writereg_e_d  = regdst_d ? rd : rt;
    srca_e_d      = rd1;
    srcb_e_d      = alusrc_d ? signimm : rd2;
    writedata_e_d = rd2;
    if (flush_e || stall_d) begin
      valid_e_d     = 1'b0;
      ctrl_e_d      = CtrlBubble;
      writereg_e_d  = '0;
      srca_e_d      = '0;
      srcb_e_d      = '0;
      writedata_e_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_e_q     <= 1'b0;
      ctrl_e_q      <= CtrlBubble;
      writereg_e_q  <= '0;
      srca_e_q      <= '0;
      srcb_e_q      <= '0;
      writedata_e_q <= '0;
    end else begin
      valid_e_q     <= valid_e_d;
      ctrl_e_q      <= ctrl_e_d;
      writereg_e_q  <= writereg_e_d;
      srca_e_q      <= srca_e_d;
      srcb_e_q      <= srcb_e_d;
      writedata_e_q <= writedata_e_d;
    end
  end

  assign valid_e      = valid_e_q;
  assign regwrite_e   = ctrl_e_q.regwrite;
  assign memtoreg_e   = ctrl_e_q.memtoreg;
  assign memwrite_e   = ctrl_e_q.memwrite;
  assign alucontrol_e = ctrl_e_q.alucontrol;
  assign writereg_e   = writereg_e_q;
  assign srca_e       = srca_e_q;
  assign srcb_e       = srcb_e_q;
  assign writedata_e  = writedata_e_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, a register sweep after reset and
// random traffic, all compared against a behavioural pipeline/regfile model.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memtoreg;
    logic        memwrite;
    logic [2:0]  aluc;
    logic [4:0]  wreg;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [31:0] wdata;
  } e_t;

  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic [4:0]  ctl;  // {regwrite, memtoreg, memwrite, alusrc, regdst}
    logic [2:0]  aluc;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic        flush;
    logic        rst_n;
    logic        exp_stall;
    e_t          exp_e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_d;
  logic        valid_d, regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d;
  logic [2:0]  alucontrol_d;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic        flush_e;
  logic [31:0] srca_e, srcb_e, writedata_e;
  logic [2:0]  alucontrol_e;
  logic [4:0]  writereg_e;
  logic        regwrite_e, memtoreg_e, memwrite_e, valid_e, stall_d;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] rf_m [32];
  e_t          e_m;
  vec_t        vecs [13];

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk          (clk),
    .reset        (reset),
    .instr_d      (instr_d),
    .valid_d      (valid_d),
    .regwrite_d   (regwrite_d),
    .memtoreg_d   (memtoreg_d),
    .memwrite_d   (memwrite_d),
    .alusrc_d     (alusrc_d),
    .regdst_d     (regdst_d),
    .alucontrol_d (alucontrol_d),
    .we3          (we3),
    .wa3          (wa3),
    .wd3          (wd3),
    .flush_e      (flush_e),
    .srca_e       (srca_e),
    .srcb_e       (srcb_e),
    .writedata_e  (writedata_e),
    .alucontrol_e (alucontrol_e),
    .writereg_e   (writereg_e),
    .regwrite_e   (regwrite_e),
    .memtoreg_e   (memtoreg_e),
    .memwrite_e   (memwrite_e),
    .valid_e      (valid_e),
    .stall_d      (stall_d)
  );

  function automatic e_t dut_e();
    return {valid_e, regwrite_e, memtoreg_e, memwrite_e, alucontrol_e, writereg_e,
            srca_e, srcb_e, writedata_e};
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %b, want %b", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_e(input string name, input e_t act, input e_t exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got v=%b rw=%b m2r=%b mw=%b alu=%b wr=%0d a=%h b=%h wd=%h, want v=%b rw=%b m2r=%b mw=%b alu=%b wr=%0d a=%h b=%h wd=%h",
               name, act.valid, act.regwrite, act.memtoreg, act.memwrite, act.aluc, act.wreg,
               act.srca, act.srcb, act.wdata, exp.valid, exp.regwrite, exp.memtoreg,
               exp.memwrite, exp.aluc, exp.wreg, exp.srca, exp.srcb, exp.wdata);
    end else begin
      n_pass++;
    end
  endtask

  // Model register read: $0 is zero, a same-cycle write is visible immediately.
  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (we3 && wa3 == a) return wd3;
    return rf_m[a];
  endfunction

  function automatic logic m_stall();
    logic [4:0] rs, rt;
    logic       needs_rt;
    rs       = instr_d[25:21];
    rt       = instr_d[20:16];
    needs_rt = !alusrc_d || memwrite_d;
    return valid_d && e_m.valid && e_m.memtoreg && e_m.regwrite && e_m.wreg != 5'd0 &&
           (e_m.wreg == rs || (needs_rt && e_m.wreg == rt));
  endfunction

  task automatic drive(input logic [31:0] instr, input logic valid, input logic [4:0] ctl,
                       input logic [2:0] aluc, input logic w_en, input logic [4:0] w_addr,
                       input logic [31:0] w_data, input logic flush, input logic rst_n);
    instr_d = instr;
    valid_d = valid;
    {regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d} = ctl;
    alucontrol_d = aluc;
    we3 = w_en;
    wa3 = w_addr;
    wd3 = w_data;
    flush_e = flush;
    reset = rst_n;
  endtask

  // One clock: check stall before the edge, advance model, check E after the edge.
  task automatic step(input string name);
    e_t   nxt;
    logic st;
    #1;
    st = m_stall();
    check_bit({name, " stall_d"}, stall_d, st);
    nxt = '0;
    if (reset && !flush_e && !st) begin
      nxt.valid    = valid_d;
      nxt.regwrite = valid_d && regwrite_d;
      nxt.memtoreg = valid_d && memtoreg_d;
      nxt.memwrite = valid_d && memwrite_d;
      nxt.aluc     = valid_d ? alucontrol_d : 3'b000;
      nxt.wreg     = regdst_d ? instr_d[15:11] : instr_d[20:16];
      nxt.srca     = m_read(instr_d[25:21]);
      nxt.srcb     = alusrc_d ? 32'(signed'(instr_d[15:0])) : m_read(instr_d[20:16]);
      nxt.wdata    = m_read(instr_d[20:16]);
    end
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_m[i] = 32'h0;
    end else if (we3 && wa3 != 5'd0) begin
      rf_m[wa3] = wd3;
    end
    @(posedge clk);
    #1;
    e_m = nxt;
    check_e({name, " E"}, dut_e(), e_m);
  endtask

  initial begin
    logic [31:0] r_instr;

    // {instr, valid, ctl, aluc, we3, wa3, wd3, flush, rst_n, exp_stall, exp_e}
    vecs[0]  = '{32'h0, 1'b0, 5'b00000, 3'b000, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, '0};
    vecs[1]  = '{32'h0, 1'b0, 5'b00000, 3'b000, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, '0};
    vecs[2]  = '{32'h0, 1'b0, 5'b00000, 3'b000, 1'b1, 5'd8, 32'h5, 1'b0, 1'b1, 1'b0, '0};
    // add $10,$8,$8
    vecs[3]  = '{32'h0108_5020, 1'b1, 5'b10001, 3'b010, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0,
                 e_t'{1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 5'd10, 32'd5, 32'd5, 32'd5}};
    // sw $9,-4($0) with $9 written the same cycle
    vecs[4]  = '{32'hAC09_FFFC, 1'b1, 5'b00110, 3'b010, 1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0, 1'b1,
                 1'b0, e_t'{1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 5'd9, 32'h0, 32'hFFFF_FFFC,
                            32'hDEAD_BEEF}};
    // lw $4,0($0)
    vecs[5]  = '{32'h8C04_0000, 1'b1, 5'b11010, 3'b010, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0,
                 e_t'{1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 5'd4, 32'h0, 32'h0, 32'h0}};
    // add $5,$4,$4 stalls once, then enters E
    vecs[6]  = '{32'h0084_2820, 1'b1, 5'b10001, 3'b010, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1, '0};
    vecs[7]  = '{32'h0084_2820, 1'b1, 5'b10001, 3'b010, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0,
                 e_t'{1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 5'd5, 32'h0, 32'h0, 32'h0}};
    // sub $6,$1,$2 flushed; write to $0 attempted
    vecs[8]  = '{32'h0022_3022, 1'b1, 5'b10001, 3'b110, 1'b1, 5'd0, 32'h1234, 1'b1, 1'b1, 1'b0,
                 '0};
    // add $7,$0,$0 reads $0 as zero
    vecs[9]  = '{32'h0000_3820, 1'b1, 5'b10001, 3'b010, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0,
                 e_t'{1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 5'd7, 32'h0, 32'h0, 32'h0}};
    vecs[10] = '{32'h8C04_0000, 1'b1, 5'b11010, 3'b010, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0,
                 e_t'{1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 5'd4, 32'h0, 32'h0, 32'h0}};
    // reset with lw in E and a dependent add in D
    vecs[11] = '{32'h0084_2820, 1'b1, 5'b10001, 3'b010, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, '0};
    // $8 must read back cleared
    vecs[12] = '{32'h0108_5020, 1'b1, 5'b10001, 3'b010, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0,
                 e_t'{1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 5'd10, 32'h0, 32'h0, 32'h0}};

    for (int i = 0; i < 32; i++) rf_m[i] = 32'h0;
    e_m = '0;
    drive(32'h0, 1'b0, 5'b0, 3'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].instr, vecs[i].valid, vecs[i].ctl, vecs[i].aluc, vecs[i].we3, vecs[i].wa3,
            vecs[i].wd3, vecs[i].flush, vecs[i].rst_n);
      #1;
      check_bit($sformatf("vec%0d tbl stall_d", i), stall_d, vecs[i].exp_stall);
      step($sformatf("vec%0d model", i));
      check_e($sformatf("vec%0d tbl", i), dut_e(), vecs[i].exp_e);
    end

    // Every register reads zero after the reset above.
    for (int r = 1; r < 32; r++) begin
      r_instr = 32'h0000_0820;
      r_instr[25:21] = 5'(r);
      r_instr[20:16] = 5'(r);
      drive(r_instr, 1'b1, 5'b10001, 3'b010, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
      step($sformatf("sweep r%0d", r));
      check_bit($sformatf("sweep r%0d zero", r), (srca_e == 32'h0) && (srcb_e == 32'h0), 1'b1);
    end

    // Random traffic on a narrow register window so hazards and bypasses are frequent.
    for (int n = 0; n < 400; n++) begin
      r_instr = $urandom;
      r_instr[25:21] = 5'($urandom_range(0, 7));
      r_instr[20:16] = 5'($urandom_range(0, 7));
      r_instr[15:11] = 5'($urandom_range(0, 7));
      drive(r_instr, $urandom_range(0, 7) != 0, 5'($urandom), 3'($urandom),
            1'($urandom), 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 15) == 0,
            $urandom_range(0, 63) != 0);
      step($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
